fft16_peak_detect: RTL and testbench
====================================

Name: fft16_peak_detect

Overview:
- Sits directly downstream of the 16-point sequential FFT.
- Consumes the FFT's serial output stream of 16 complex bins. The stream is framed by a one-cycle pulse derived from the FFT DONE.
- Computes each bin's squared magnitude and tracks the strongest bin over a configurable bin range.
- Reports peak bin index, peak magnitude and a threshold-hit flag with a one-cycle VALID pulse. Game/audio control logic uses these as a spectral trigger.

Parameters:
- N, 16, bins per frame (power of 2; counter width log2(N)).
- W, 16, bits per real/imag component (two's complement).
- FIRST_BIN, 1, lowest bin index eligible for peak search (1 = skip DC).
- LAST_BIN, 7, highest eligible bin index (7 = positive-frequency half for real input).
- THRESH, 32'd4096, minimum squared magnitude for HIT=1.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- Y_IN  in  2W  FFT bin sample; [2W-1:W] = real, [W-1:0] = imag, both signed.
- FRAME_START  in  1  one-cycle pulse: Y_IN holds bin 0 in this same cycle.
- BUSY  out  1  high while a frame is being collected or flushed through the pipeline.
- VALID  out  1  one-cycle pulse: PEAK_* and HIT are updated.
- PEAK_BIN  out  log2(N)  index of the strongest eligible bin.
- PEAK_MAG  out  2W  squared magnitude of that bin, unsigned.
- HIT  out  1  PEAK_MAG >= THRESH.

Behaviour:
Reset:
- RESET high at a posedge clears all state.
- BUSY=0, VALID=0, PEAK_BIN=0, PEAK_MAG=0, HIT=0.
- FSM goes to IDLE, bin counter=0, pipeline valid bits=0.
- Reset mid-frame discards that frame; no VALID follows.

FSM states:
- IDLE: waits for FRAME_START. On FRAME_START, samples bin 0, sets counter=1, BUSY=1, goes to COLLECT.
- COLLECT: samples one bin per cycle with no gaps (the FFT shift-out is gapless). Counter increments. When bin N-1 is sampled, goes to FLUSH.
- FLUSH: waits for the pipeline to drain (2 cycles), then goes to REPORT.
- REPORT: one cycle. Registers outputs, pulses VALID, clears BUSY, returns to IDLE.

Pipeline, per sampled bin k at cycle t:
- t+1: registers re*re and im*im. Each product is 2W-1 bits unsigned; (-2^(W-1))^2 = 2^(2W-2) must be exact.
- t+2: registers mag = re^2 + im^2 in 2W bits unsigned. Max 2^(2W-1) fits; no saturation needed.
- t+2, same edge: compare stage updates running max if FIRST_BIN <= k <= LAST_BIN and mag > current max.
  - Strictly greater, so ties keep the lower index.
  - The running max is initialised to mag 0, bin FIRST_BIN at frame start.

Latency:
- Bin 0 arrives at cycle T with FRAME_START.
- Bin 15 is sampled at cycle T+15.
- VALID is high during cycle T+18: outputs register at the edge ending T+17 and are visible in T+18.
- BUSY is high for cycles T+1..T+17.

Outputs:
- PEAK_BIN, PEAK_MAG and HIT hold their values until the next VALID or RESET.
- All-zero frame reports PEAK_BIN=FIRST_BIN, PEAK_MAG=0, HIT=0.

Boundary conditions:
- FRAME_START during COLLECT aborts the current frame. The new frame starts with bin 0 in that cycle, the counter reloads to 1, the running max is re-initialised, and there is no VALID for the aborted frame.
- FRAME_START during FLUSH or REPORT is also accepted as a new frame. The pending result is still reported at its scheduled cycle, and the new frame's pipeline entries are tagged separately so they do not corrupt it. The implementation carries a frame-tag bit through the pipeline.
- Back-to-back frames with FRAME_START every 16 cycles give exactly one VALID per frame, 18 cycles after each FRAME_START.
- Bins outside [FIRST_BIN, LAST_BIN] are squared but ignored by the comparator.
- Y_IN is ignored in IDLE unless FRAME_START=1.

Test Plan:
- Reset then idle: hold RESET 2 cycles, drive random Y_IN with no FRAME_START for 40 cycles -> VALID never asserts, all outputs 0, BUSY 0.
- Single tone: FRAME_START at T, bin 3 = (re=100, im=-50), all other bins 0 -> VALID only at T+18, PEAK_BIN=3, PEAK_MAG=12500, HIT=1; BUSY high T+1..T+17.
- DC and mirror exclusion: bin 0=(30000,0), bin 13=(20000,0), bin 5=(10,10) -> PEAK_BIN=5, PEAK_MAG=200, HIT=0.
- Tie and extreme: bins 2 and 6 both (-32768,-32768) -> PEAK_BIN=2, PEAK_MAG=2147483648 (0x80000000), HIT=1.
- Abort/restart: FRAME_START at T, second FRAME_START at T+7 with bin 4=(64,0) in the new frame -> exactly one VALID at T+25, PEAK_BIN=4, PEAK_MAG=4096, HIT=1.
- Back-to-back plus reset: three frames at T, T+16, T+32 with peaks at bins 1, 7, 3 -> VALIDs at T+18, T+34 with bins 1 and 7; RESET asserted at T+40 -> third frame produces no VALID, outputs cleared to 0.

Source files
------------

// File: rtl/fft16_peak_detect_if.sv
// Streaming bus between the FFT shift-out and the peak detector.
// The master side feeds bins; the slave side returns the peak report.
interface fft16_peak_detect_if #(
   parameter int N = 16,
   parameter int W = 16
);
   localparam int BW = $clog2(N);

   logic [2*W-1:0] Y_IN;
   logic           FRAME_START;
   logic           BUSY;
   logic           VALID;
   logic [BW-1:0]  PEAK_BIN;
   logic [2*W-1:0] PEAK_MAG;
   logic           HIT;

   modport master (
      output Y_IN, FRAME_START,
      input  BUSY, VALID, PEAK_BIN, PEAK_MAG, HIT
   );

   modport slave (
      input  Y_IN, FRAME_START,
      output BUSY, VALID, PEAK_BIN, PEAK_MAG, HIT
   );
endinterface

// File: rtl/fft16_peak_detect.sv
// Squares each FFT bin and tracks the strongest bin within [FIRST_BIN, LAST_BIN].
// Two running-max banks, selected by a frame tag, let a new frame overlap the previous report.
module fft16_peak_detect #(
   parameter int          N         = 16,
   parameter int          W         = 16,
   parameter int          FIRST_BIN = 1,
   parameter int          LAST_BIN  = 7,
   parameter logic [31:0] THRESH    = 32'd4096
) (
   input logic                CLK,
   input logic                RESET,
   fft16_peak_detect_if.slave bus
);
   localparam int            BW       = $clog2(N);
   localparam logic [BW-1:0] FIRST_B  = BW'(FIRST_BIN);
   localparam logic [BW-1:0] LAST_B   = BW'(LAST_BIN);
   localparam logic [BW-1:0] LAST_CNT = BW'(N - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, REPORT} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [BW-1:0]         r_cnt;
   logic                  r_tag;

   logic                  w_fs;
   logic                  w_take;
   logic                  w_last;
   logic [BW-1:0]         w_bin;
   logic signed [2*W-1:0] w_re_x;
   logic signed [2*W-1:0] w_im_x;
   logic [2*W-1:0]        w_mag;
   logic                  w_elig;

   logic                  r_p_vld;
   logic [BW-1:0]         r_p_bin;
   logic                  r_p_tag;
   logic [2*W-1:0]        r_re_sq;
   logic [2*W-1:0]        r_im_sq;

   logic [2*W-1:0]        r_max_mag [2];
   logic [BW-1:0]         r_max_bin [2];

   logic                  r_d1, r_d1_tag, r_d2, r_d2_tag;
   logic                  r_valid;
   logic [BW-1:0]         r_peak_bin;
   logic [2*W-1:0]        r_peak_mag;
   logic                  r_hit;

   assign w_fs   = bus.FRAME_START;
   assign w_take = w_fs || (r_state == COLLECT);
   assign w_bin  = w_fs ? '0 : r_cnt;
   assign w_last = (r_state == COLLECT) && !w_fs && (r_cnt == LAST_CNT);
   assign w_re_x = $signed({{W{bus.Y_IN[2*W-1]}}, bus.Y_IN[2*W-1:W]});
   assign w_im_x = $signed({{W{bus.Y_IN[W-1]}}, bus.Y_IN[W-1:0]});
   assign w_mag  = r_re_sq + r_im_sq;
   assign w_elig = (r_p_bin >= FIRST_B) && (r_p_bin <= LAST_B);

   // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: always_comb assigns a default first so no path leaves the signal unassigned and infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      if (w_fs) begin
         w_state_nxt = COLLECT;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = IDLE;
            COLLECT: if (r_cnt == LAST_CNT) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = REPORT;
            REPORT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.BUSY = (r_state != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cnt   <= '0;
         r_tag   <= 1'b0;
         r_p_vld <= 1'b0;
         r_p_bin <= '0;
         r_p_tag <= 1'b0;
         r_re_sq <= '0;
         r_im_sq <= '0;
      end else begin
         if (w_fs)                      r_cnt <= BW'(1);
         else if (r_state == COLLECT)   r_cnt <= r_cnt + 1'b1;
         if (w_fs) r_tag <= ~r_tag;
         r_p_vld <= w_take;
         r_p_bin <= w_bin;
         r_p_tag <= w_fs ? ~r_tag : r_tag;
         r_re_sq <= w_re_x * w_re_x;
         r_im_sq <= w_im_x * w_im_x;
      end
   end

   // NOTE: the two-entry running-max banks are cleared on reset; they are tiny registers, not RAM.
   // Frame-start re-initialisation is written last so it wins over a stale compare to the same bank.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < 2; i++) begin
            r_max_mag[i] <= '0;
            r_max_bin[i] <= FIRST_B;
         end
      end else begin
         if (r_p_vld && w_elig && (w_mag > r_max_mag[r_p_tag])) begin
            r_max_mag[r_p_tag] <= w_mag;
            r_max_bin[r_p_tag] <= r_p_bin;
         end
         if (w_fs) begin
            r_max_mag[~r_tag] <= '0;
            r_max_bin[~r_tag] <= FIRST_B;
         end
      end
   end

   // Report is scheduled two cycles after the last bin, independent of the FSM, so overlap is safe.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_d1       <= 1'b0;
         r_d1_tag   <= 1'b0;
         r_d2       <= 1'b0;
         r_d2_tag   <= 1'b0;
         r_valid    <= 1'b0;
         r_peak_bin <= '0;
         r_peak_mag <= '0;
         r_hit      <= 1'b0;
      end else begin
         r_d1     <= w_last;
         r_d1_tag <= r_tag;
         r_d2     <= r_d1;
         r_d2_tag <= r_d1_tag;
         r_valid  <= r_d2;
         if (r_d2) begin
            r_peak_bin <= r_max_bin[r_d2_tag];
            r_peak_mag <= r_max_mag[r_d2_tag];
            r_hit      <= (r_max_mag[r_d2_tag] >= THRESH);
         end
      end
   end

   assign bus.VALID    = r_valid;
   assign bus.PEAK_BIN = r_peak_bin;
   assign bus.PEAK_MAG = r_peak_mag;
   assign bus.HIT      = r_hit;
endmodule

// File: tb/tb_fft16_peak_detect.sv
// Directed bench: stimulus pushes hand-computed reports into a scoreboard;
// a negedge monitor pops and compares whenever VALID is seen.
module tb_fft16_peak_detect;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   typedef struct {
      int          cyc;
      logic [3:0]  bin;
      logic [31:0] mag;
      bit          hit;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] frame [16];
   bit          bw_arm = 1'b0;
   bit          bw_en  = 1'b0;
   int          bw_t   = 0;

   fft16_peak_detect_if #(.N(16), .W(16)) bus ();

   fft16_peak_detect #(
      .N(16), .W(16), .FIRST_BIN(1), .LAST_BIN(7), .THRESH(32'd4096)
   ) dut (
      .CLK  (clk),
      .RESET(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: scoreboard compare on VALID, missed-report detection, and BUSY window checks.
   always @(negedge clk) begin
      if (bus.VALID === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 64'(bus.VALID), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("valid_cycle", 64'(cyc), 64'(e.cyc));
            check("peak_bin", 64'(bus.PEAK_BIN), 64'(e.bin));
            check("peak_mag", 64'(bus.PEAK_MAG), 64'(e.mag));
            check("hit", 64'(bus.HIT), 64'(e.hit));
         end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
         check("missing_valid", 64'(cyc), 64'(sb[0].cyc));
         void'(sb.pop_front());
      end
      if (bw_en && cyc >= bw_t && cyc <= bw_t + 18)
         check("busy_window", 64'(bus.BUSY), 64'((cyc >= bw_t + 1) && (cyc <= bw_t + 17)));
   end

   task automatic clear_frame();
      for (int k = 0; k < 16; k++) frame[k] = '0;
   endtask

   task automatic set_bin(input int k, input int re, input int im);
      frame[k] = {16'(re), 16'(im)};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.FRAME_START = 1'b0;
         bus.Y_IN        = '0;
      end
   endtask

   task automatic run_frame(input int nbins, input bit exp_v, input logic [3:0] eb,
                            input logic [31:0] em, input bit eh);
      for (int k = 0; k < nbins; k++) begin
         @(posedge clk); #1;
         bus.FRAME_START = (k == 0);
         bus.Y_IN        = frame[k];
         if (k == 0) begin
            if (exp_v) sb.push_back('{cyc + 18, eb, em, eh});
            if (bw_arm) begin
               bw_t  = cyc;
               bw_en = 1'b1;
            end
         end
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.FRAME_START = 1'b0;
      bus.Y_IN        = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Idle with random data and no frame start: nothing may move.
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         bus.FRAME_START = 1'b0;
         bus.Y_IN        = $urandom;
         @(negedge clk);
         check("idle_outputs",
               64'({bus.BUSY, bus.VALID, bus.PEAK_BIN, bus.PEAK_MAG, bus.HIT}), 64'd0);
      end

      // Single tone at bin 3: 100^2 + 50^2 = 12500.
      clear_frame();
      set_bin(3, 100, -50);
      bw_arm = 1'b1;
      run_frame(16, 1'b1, 4'd3, 32'd12500, 1'b1);
      bw_arm = 1'b0;
      idle(25);
      bw_en = 1'b0;

      // DC and mirror bins are excluded: winner is bin 5 with 200.
      clear_frame();
      set_bin(0, 30000, 0);
      set_bin(13, 20000, 0);
      set_bin(5, 10, 10);
      run_frame(16, 1'b1, 4'd5, 32'd200, 1'b0);
      idle(25);

      // Tie at the extreme value keeps the lower index: 2 * 2^30.
      clear_frame();
      set_bin(2, -32768, -32768);
      set_bin(6, -32768, -32768);
      run_frame(16, 1'b1, 4'd2, 32'h8000_0000, 1'b1);
      idle(25);

      // Abort at T+7: the large bin of the aborted frame must be forgotten.
      clear_frame();
      set_bin(2, 20000, 0);
      run_frame(7, 1'b0, 4'd0, 32'd0, 1'b0);
      clear_frame();
      set_bin(4, 64, 0);
      run_frame(16, 1'b1, 4'd4, 32'd4096, 1'b1);
      idle(25);

      // Back-to-back frames, the third one killed by reset at T+40.
      clear_frame();
      set_bin(1, 1000, 0);
      set_bin(3, 30, 0);
      run_frame(16, 1'b1, 4'd1, 32'd1000000, 1'b1);
      clear_frame();
      set_bin(7, 0, 200);
      set_bin(2, 100, 0);
      run_frame(16, 1'b1, 4'd7, 32'd40000, 1'b1);
      clear_frame();
      set_bin(3, 50, 0);
      run_frame(8, 1'b0, 4'd0, 32'd0, 1'b0);
      @(posedge clk); #1;
      bus.FRAME_START = 1'b0;
      bus.Y_IN        = '0;
      rst             = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_outputs",
            64'({bus.BUSY, bus.VALID, bus.PEAK_BIN, bus.PEAK_MAG, bus.HIT}), 64'd0);
      idle(30);
      check("post_reset_hold",
            64'({bus.BUSY, bus.PEAK_BIN, bus.PEAK_MAG, bus.HIT}), 64'd0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
